// File: rtl/alu_result_collector_if.sv
// Bundle of ALU unit result buses, the downstream valid/ready port and status outputs.
// The master side drives unit results and Res_Ready; the slave side is the collector.
interface alu_result_collector_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0]         Arith_Out;
  logic                     Arith_Flag;
  logic [WIDTH-1:0]         Logic_Out;
  logic                     Logic_Flag;
  logic [WIDTH-1:0]         CMP_Out;
  logic                     CMP_Flag;
  logic [WIDTH-1:0]         Shift_Out;
  logic                     Shift_Flag;
  logic [WIDTH-1:0]         Res_Out;
  logic [1:0]               Res_Unit;
  logic                     Res_Valid;
  logic                     Res_Ready;
  logic [$clog2(DEPTH):0]   Level;
  logic                     Ovf_Flag;
  logic                     Col_Flag;
  logic [CNT_W-1:0]         Drop_Cnt;

  modport master (
    output Arith_Out, Arith_Flag, Logic_Out, Logic_Flag,
    output CMP_Out, CMP_Flag, Shift_Out, Shift_Flag, Res_Ready,
    input  Res_Out, Res_Unit, Res_Valid, Level, Ovf_Flag, Col_Flag, Drop_Cnt
  );

  modport slave (
    input  Arith_Out, Arith_Flag, Logic_Out, Logic_Flag,
    input  CMP_Out, CMP_Flag, Shift_Out, Shift_Flag, Res_Ready,
    output Res_Out, Res_Unit, Res_Valid, Level, Ovf_Flag, Col_Flag, Drop_Cnt
  );
endinterface

// File: rtl/alu_result_collector.sv
// Captures ALU unit results by fixed priority, tags them with their source unit and
// buffers them in a show-ahead FIFO drained over a valid/ready handshake.
module alu_result_collector #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_collector_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned EntW = WIDTH + 2;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             ovf_q, col_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [3:0]       flags;
  logic [EntW-1:0]  entry;
  logic             push_req, push_ok, pop, full, drop, collide;

  always_comb begin
    flags = {bus.Shift_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag};
    push_req = |flags;
    // Priority Arith > Logic > CMP > Shift; the tag sits above the data bits.
    if (bus.Arith_Flag)      entry = {2'b00, bus.Arith_Out};
    else if (bus.Logic_Flag) entry = {2'b01, bus.Logic_Out};
    else if (bus.CMP_Flag)   entry = {2'b10, bus.CMP_Out};
    else                     entry = {2'b11, bus.Shift_Out};
    full    = (level_q == LvlW'(DEPTH));
    pop     = (level_q != '0) && bus.Res_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = push_req && (!full || pop);
    drop    = push_req && full && !pop;
    collide = (flags & (flags - 4'd1)) != 4'd0;
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      col_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q <= level_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
      end
      if (collide) begin
        col_q <= 1'b1;
      end
    end
  end

  logic [EntW-1:0] head;
  assign head          = mem_q[rd_ptr_q];
  assign bus.Res_Out   = head[WIDTH-1:0];
  assign bus.Res_Unit  = head[EntW-1:WIDTH];
  assign bus.Res_Valid = (level_q != '0);
  assign bus.Level     = level_q;
  assign bus.Ovf_Flag  = ovf_q;
  assign bus.Col_Flag  = col_q;
  assign bus.Drop_Cnt  = drop_cnt_q;

endmodule
